execute_stage_pipe: RTL and testbench
=====================================

Name: execute_stage_pipe

Overview:
- Parametrised, pipelined successor to the SEQUENTIAL execute block for the Y86-64 pipeline.
- Computes valE and cnd for one instruction per handshake and owns the architectural condition-code register.
- Adds valid/ready flow control, CC-update suppression on downstream exceptions, and conditional-move destination cancelling.
- Sits between the decode pipeline register (D/E) and memory; its output register is the E/M pipeline register.

Parameters:
- WIDTH, 64, data width of valA/valB/valC/valE.
- STACK_STEP, 8, byte adjustment applied to %rsp by call/push/ret/pop.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears state.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- valA  in  WIDTH  operand A.
- valB  in  WIDTH  operand B.
- valC  in  WIDTH  immediate / displacement.
- dstE_in  in  4  E destination register ID.
- dstM_in  in  4  M destination register ID.
- stat_in  in  2  status (0 AOK, 1 HLT, 2 ADR, 3 INS).
- squash_cc  in  1  memory/writeback stage holds a non-AOK status; blocks CC updates.
- out_valid  out  1  E/M register holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- icode_out  out  4  registered icode.
- cnd_out  out  1  registered condition result.
- valE_out  out  WIDTH  registered ALU result.
- valA_out  out  WIDTH  registered valA (store data / return address).
- dstE_out  out  4  registered dstE; RNONE if a cmov is not taken.
- dstM_out  out  4  registered dstM.
- stat_out  out  2  registered status.
- cc_out  out  3  CC register: bit0 ZF, bit1 SF, bit2 OF.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, icode_out=1 (nop), cnd_out=0, valE_out=0, valA_out=0.
  - dstE_out=RNONE, dstM_out=RNONE, stat_out=0.
  - cc_out=3'b001 (ZF set).
  - Reset mid-transfer discards the in-flight instruction.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready. On accept, all *_out load on the next rising edge and out_valid<=1.
  - Otherwise, out_ready && out_valid clears out_valid; all other *_out hold.
  - Latency is 1 cycle. Sustained throughput is 1 instruction/cycle when out_ready=1.
- valE, combinational from the inputs, registered on accept:
  - cmovXX (2): valA.
  - irmovq (3): valC.
  - rmmovq/mrmovq (4/5): valB+valC.
  - OPq (6) by ifun: 0 valB+valA; 1 valB-valA; 2 valB&valA; 3 valB^valA; any other ifun gives stat INS.
  - call/pushq (8/A): valB-STACK_STEP.
  - ret/popq (9/B): valB+STACK_STEP.
  - All other icodes: 0.
  - All arithmetic is modulo 2^WIDTH.
- CC update: on accept only, when icode==6, ifun<=3, stat_in==AOK and squash_cc==0.
  - ZF = (result==0).
  - SF = result[WIDTH-1].
  - OF: for add, operands share a sign and the result sign differs; for sub, valB and valA signs differ and the result sign differs from valB; for and/xor, OF=0.
  - The new CC is visible on cc_out the cycle after accept.
- cnd: evaluated from the current cc_out (before this instruction's update), only for icode 2 or 7.
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - ifun>6: cnd=0 and stat INS.
  - Any other icode: cnd=0.
- Destination and status:
  - cmov with cnd=0: dstE_out=RNONE. Otherwise dstE_out=dstE_in.
  - stat_out = stat_in, unless it is AOK and an invalid ifun was detected (then INS).
- Back-to-back OPq: the second instruction sees the first one's CC, because the first update lands in the same edge that accepts the first and precedes evaluation of the second.
- Stall (out_ready=0, out_valid=1): inputs are not consumed and the CC does not change.

Test Plan:
- Reset asserted mid-stream -> out_valid=0, cc_out=001, dstE_out=F, with no clock edge required.
- OPq add, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> valE_out=0x8000_0000_0000_0000; next cycle cc_out=110 (OF=1, SF=1, ZF=0).
- OPq sub, valA=5, valB=5, then cmovle (ifun 1), dstE_in=3 -> first valE=0 with cc=001; cmov cnd_out=1, dstE_out=3.
- cmovl after cc=001 -> cnd_out=0, dstE_out=F, valE_out=valA.
- pushq, valB=0x100 -> valE_out=0xF8; popq, valB=0xF8 -> 0x100.
- OPq xor with squash_cc=1 -> cc_out unchanged.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. On release, the queued instruction appears 1 cycle later.

Source files
------------

// File: rtl/execute_stage_pipe.sv
// Y86-64 execute stage with valid/ready handshake; the output register is the E/M pipeline register.
// Computes valE and cnd, owns the condition-code register and cancels untaken cmov destinations.
module execute_stage_pipe #(
  parameter int         WIDTH      = 64,
  parameter int         STACK_STEP = 8,
  parameter logic [3:0] RNONE      = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic [3:0]       dstE_in,
  input  logic [3:0]       dstM_in,
  input  logic [1:0]       stat_in,
  input  logic             squash_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       icode_out,
  output logic             cnd_out,
  output logic [WIDTH-1:0] valE_out,
  output logic [WIDTH-1:0] valA_out,
  output logic [3:0]       dstE_out,
  output logic [3:0]       dstM_out,
  output logic [1:0]       stat_out,
  output logic [2:0]       cc_out
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_INS = 2'd3;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  logic             accept;
  logic             zf, sf, of;
  logic             cnd_next;
  logic             bad_ifun;
  logic [WIDTH-1:0] vale_next;
  logic             alu_of;
  logic             cc_update;
  logic [2:0]       cc_next;
  logic [3:0]       dste_next;
  logic [1:0]       stat_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign zf = cc_out[0];
  assign sf = cc_out[1];
  assign of = cc_out[2];

  // Condition evaluation uses the CC currently held, i.e. before this instruction's update.
  always_comb begin
    cnd_next = 1'b0;
    bad_ifun = 1'b0;
    if (icode == 4'h2 || icode == 4'h7) begin
      case (ifun)
        4'h0:    cnd_next = 1'b1;
        4'h1:    cnd_next = (sf ^ of) | zf;
        4'h2:    cnd_next = sf ^ of;
        4'h3:    cnd_next = zf;
        4'h4:    cnd_next = !zf;
        4'h5:    cnd_next = !(sf ^ of);
        4'h6:    cnd_next = !(sf ^ of) && !zf;
        default: bad_ifun = 1'b1;
      endcase
    end else if (icode == 4'h6 && ifun > 4'h3) begin
      bad_ifun = 1'b1;
    end
  end

  always_comb begin
    vale_next = '0;
    alu_of    = 1'b0;
    case (icode)
      4'h2:       vale_next = valA;
      4'h3:       vale_next = valC;
      4'h4, 4'h5: vale_next = valB + valC;
      4'h6: begin
        case (ifun)
          4'h0: begin
            vale_next = valB + valA;
            alu_of    = (valA[WIDTH-1] == valB[WIDTH-1]) && (vale_next[WIDTH-1] != valB[WIDTH-1]);
          end
          4'h1: begin
            vale_next = valB - valA;
            alu_of    = (valA[WIDTH-1] != valB[WIDTH-1]) && (vale_next[WIDTH-1] != valB[WIDTH-1]);
          end
          4'h2:    vale_next = valB & valA;
          4'h3:    vale_next = valB ^ valA;
          default: vale_next = '0;
        endcase
      end
      4'h8, 4'hA: vale_next = valB - STEP;
      4'h9, 4'hB: vale_next = valB + STEP;
      default:    vale_next = '0;
    endcase
  end

  // Faulting instructions further down the pipe must not leave a trace in the CC.
  assign cc_update = accept && icode == 4'h6 && !bad_ifun && stat_in == STAT_AOK && !squash_cc;
  assign cc_next   = {alu_of, vale_next[WIDTH-1], (vale_next == '0)};
  assign dste_next = (icode == 4'h2 && !cnd_next) ? RNONE : dstE_in;
  assign stat_next = (stat_in == STAT_AOK && bad_ifun) ? STAT_INS : stat_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      icode_out <= 4'h1;
      cnd_out   <= 1'b0;
      valE_out  <= '0;
      valA_out  <= '0;
      dstE_out  <= RNONE;
      dstM_out  <= RNONE;
      stat_out  <= STAT_AOK;
      cc_out    <= 3'b001;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        icode_out <= icode;
        cnd_out   <= cnd_next;
        valE_out  <= vale_next;
        valA_out  <= valA;
        dstE_out  <= dste_next;
        dstM_out  <= dstM_in;
        stat_out  <= stat_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (cc_update) begin
        cc_out <= cc_next;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Randomised and directed bench for execute_stage_pipe against a behavioural Y86-64 execute model.
module tb_execute_stage_pipe;

  localparam int W  = 64;
  localparam int BW = 147;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [3:0]    icode, ifun;
  logic [W-1:0]  valA, valB, valC;
  logic [3:0]    dstE_in, dstM_in;
  logic [1:0]    stat_in;
  logic          squash_cc;
  logic          out_valid, out_ready;
  logic [3:0]    icode_out;
  logic          cnd_out;
  logic [W-1:0]  valE_out, valA_out;
  logic [3:0]    dstE_out, dstM_out;
  logic [1:0]    stat_out;
  logic [2:0]    cc_out;

  int errors = 0;
  int checks = 0;

  execute_stage_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE_in(dstE_in), .dstM_in(dstM_in), .stat_in(stat_in), .squash_cc(squash_cc),
    .out_valid(out_valid), .out_ready(out_ready), .icode_out(icode_out),
    .cnd_out(cnd_out), .valE_out(valE_out), .valA_out(valA_out),
    .dstE_out(dstE_out), .dstM_out(dstM_out), .stat_out(stat_out), .cc_out(cc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] vale;
    logic         cnd;
    logic [3:0]   dste;
    logic [1:0]   stat;
    logic [2:0]   cc;
  } exp_t;

  // Expected E/M register contents and CC
  logic         e_ov;
  logic [3:0]   e_icode, e_dste, e_dstm;
  logic         e_cnd;
  logic [W-1:0] e_vale, e_vala;
  logic [1:0]   e_stat;
  logic [2:0]   e_cc;

  function automatic exp_t model(input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c, input logic [3:0] de,
                                 input logic [1:0] st, input logic sq, input logic [2:0] cc);
    exp_t r;
    logic zf, sf, of, lt, bad, ovf;
    logic [W:0] wide;
    zf = cc[0]; sf = cc[1]; of = cc[2];
    lt = (sf != of);
    bad = 1'b0; ovf = 1'b0;
    r.vale = '0; r.cnd = 1'b0; r.cc = cc;
    if (ic == 4'h2 || ic == 4'h7) begin
      if (fn == 0) r.cnd = 1'b1;
      else if (fn == 1) r.cnd = lt || zf;
      else if (fn == 2) r.cnd = lt;
      else if (fn == 3) r.cnd = zf;
      else if (fn == 4) r.cnd = !zf;
      else if (fn == 5) r.cnd = !lt;
      else if (fn == 6) r.cnd = !lt && !zf;
      else bad = 1'b1;
    end
    if (ic == 4'h2) r.vale = a;
    else if (ic == 4'h3) r.vale = c;
    else if (ic == 4'h4 || ic == 4'h5) r.vale = b + c;
    else if (ic == 4'h8 || ic == 4'hA) r.vale = b - 64'd8;
    else if (ic == 4'h9 || ic == 4'hB) r.vale = b + 64'd8;
    else if (ic == 4'h6) begin
      // exact signed result in W+1 bits: overflow iff the top two bits disagree
      if (fn == 0) begin
        wide = {b[W-1], b} + {a[W-1], a};
        r.vale = wide[W-1:0]; ovf = wide[W] ^ wide[W-1];
      end else if (fn == 1) begin
        wide = {b[W-1], b} - {a[W-1], a};
        r.vale = wide[W-1:0]; ovf = wide[W] ^ wide[W-1];
      end else if (fn == 2) r.vale = b & a;
      else if (fn == 3) r.vale = b ^ a;
      else bad = 1'b1;
      if (!bad && st == 2'd0 && !sq)
        r.cc = {ovf, r.vale[W-1], (r.vale == 0)};
    end
    r.dste = (ic == 4'h2 && !r.cnd) ? 4'hF : de;
    r.stat = (st == 2'd0 && bad) ? 2'd3 : st;
    return r;
  endfunction

  function automatic logic [BW-1:0] dut_b();
    return {out_valid, icode_out, cnd_out, valE_out, valA_out, dstE_out, dstM_out, stat_out, cc_out};
  endfunction

  function automatic logic [BW-1:0] exp_b();
    return {e_ov, e_icode, e_cnd, e_vale, e_vala, e_dste, e_dstm, e_stat, e_cc};
  endfunction

  task automatic model_reset();
    e_ov = 0; e_icode = 4'h1; e_cnd = 0; e_vale = '0; e_vala = '0;
    e_dste = 4'hF; e_dstm = 4'hF; e_stat = 0; e_cc = 3'b001;
  endtask

  // Advance one clock edge, updating the model with the handshake rules; returns at edge+1.
  task automatic tick();
    exp_t m;
    logic acc;
    acc = in_valid && (!e_ov || out_ready);
    m = model(icode, ifun, valA, valB, valC, dstE_in, stat_in, squash_cc, e_cc);
    @(posedge clk);
    if (acc) begin
      e_ov = 1; e_icode = icode; e_cnd = m.cnd; e_vale = m.vale; e_vala = valA;
      e_dste = m.dste; e_dstm = dstM_in; e_stat = m.stat; e_cc = m.cc;
    end else if (out_ready && e_ov) begin
      e_ov = 0;
    end
    #1;
  endtask

  task automatic set_in(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c, input logic [3:0] de,
                        input logic [1:0] st, input logic sq);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    dstE_in = de; dstM_in = 4'h7; stat_in = st; squash_cc = sq; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; out_ready = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    model_reset();
    #3;
    checks++;
    if (dut_b() !== exp_b()) begin
      errors++; $display("FAIL reset_state: got %h want %h", dut_b(), exp_b());
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    $display("test_reset: done");
  endtask

  task automatic test_add_overflow();
    set_in(6, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 4'h2, 0, 0);
    tick();
    in_valid = 0;
    checks++;
    if (valE_out !== 64'h8000_0000_0000_0000 || cc_out !== 3'b110) begin
      errors++; $display("FAIL add_ovf: valE=%h cc=%b want 8000000000000000 cc=110", valE_out, cc_out);
    end
    checks++;
    if (dut_b() !== exp_b()) begin
      errors++; $display("FAIL add_ovf_model: got %h want %h", dut_b(), exp_b());
    end
    $display("test_add_overflow: valE=%h cc=%b", valE_out, cc_out);
  endtask

  task automatic test_back_to_back();
    set_in(6, 1, 64'd5, 64'd5, 0, 4'h1, 0, 0);
    tick();
    checks++;
    if (valE_out !== 0 || cc_out !== 3'b001 || out_valid !== 1'b1) begin
      errors++; $display("FAIL sub_zero: valE=%h cc=%b ov=%b want 0 001 1", valE_out, cc_out, out_valid);
    end
    set_in(2, 1, 64'h1234, 64'h99, 0, 4'h3, 0, 0);
    tick();
    in_valid = 0;
    checks++;
    if (cnd_out !== 1'b1 || dstE_out !== 4'h3 || valE_out !== 64'h1234) begin
      errors++; $display("FAIL cmovle_taken: cnd=%b dstE=%h valE=%h want 1 3 1234", cnd_out, dstE_out, valE_out);
    end
    checks++;
    if (dut_b() !== exp_b()) begin
      errors++; $display("FAIL b2b_model: got %h want %h", dut_b(), exp_b());
    end
    $display("test_back_to_back: cnd=%b dstE=%h", cnd_out, dstE_out);
  endtask

  task automatic test_cmov_not_taken();
    set_in(2, 2, 64'hABC, 64'h1, 0, 4'h5, 0, 0);
    tick();
    in_valid = 0;
    checks++;
    if (cnd_out !== 1'b0 || dstE_out !== 4'hF || valE_out !== 64'hABC) begin
      errors++; $display("FAIL cmovl_not_taken: cnd=%b dstE=%h valE=%h want 0 f abc", cnd_out, dstE_out, valE_out);
    end
    $display("test_cmov_not_taken: dstE=%h", dstE_out);
  endtask

  task automatic test_stack();
    set_in(4'hA, 0, 64'h55, 64'h100, 0, 4'h4, 0, 0);
    tick();
    checks++;
    if (valE_out !== 64'hF8) begin
      errors++; $display("FAIL pushq: valE=%h want f8", valE_out);
    end
    set_in(4'hB, 0, 64'h55, 64'hF8, 0, 4'h4, 0, 0);
    tick();
    in_valid = 0;
    checks++;
    if (valE_out !== 64'h100 || icode_out !== 4'hB) begin
      errors++; $display("FAIL popq: valE=%h icode=%h want 100 b", valE_out, icode_out);
    end
    $display("test_stack: pop valE=%h", valE_out);
  endtask

  task automatic test_squash();
    logic [2:0] cc0;
    cc0 = e_cc;
    set_in(6, 3, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001, 0, 4'h2, 0, 1);
    tick();
    in_valid = 0; squash_cc = 0;
    checks++;
    if (cc_out !== cc0 || valE_out !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL squash_cc: cc=%b valE=%h want %b 8000000000000000", cc_out, valE_out, cc0);
    end
    $display("test_squash: cc=%b", cc_out);
  endtask

  task automatic test_invalid_ifun();
    logic [2:0] cc0;
    cc0 = e_cc;
    set_in(6, 5, 64'd1, 64'd2, 0, 4'h2, 0, 0);
    tick();
    checks++;
    if (stat_out !== 2'd3 || cc_out !== cc0) begin
      errors++; $display("FAIL opq_bad_ifun: stat=%0d cc=%b want 3 %b", stat_out, cc_out, cc0);
    end
    set_in(7, 9, 64'd1, 64'd2, 64'h40, 4'hF, 0, 0);
    tick();
    in_valid = 0;
    checks++;
    if (stat_out !== 2'd3 || cnd_out !== 1'b0) begin
      errors++; $display("FAIL jxx_bad_ifun: stat=%0d cnd=%b want 3 0", stat_out, cnd_out);
    end
    $display("test_invalid_ifun: stat=%0d", stat_out);
  endtask

  task automatic test_stall();
    logic [BW-1:0] snap;
    set_in(5, 0, 64'h11, 64'h1000, 64'h20, 4'hF, 0, 0);
    tick();
    snap = exp_b();
    out_ready = 0;
    set_in(3, 0, 64'h0, 64'h0, 64'h55, 4'h6, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      checks++;
      if (dut_b() !== snap) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_b(), snap);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 0;
    checks++;
    if (valE_out !== 64'h55 || icode_out !== 4'h3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL release_load: valE=%h icode=%h ov=%b want 55 3 1", valE_out, icode_out, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain: out_valid=%b want 0", out_valid);
    end
    $display("test_stall: released valE=%h", valE_out);
  endtask

  task automatic test_random();
    int bad_before;
    bad_before = errors;
    for (int n = 0; n < 400; n++) begin
      set_in(4'($urandom_range(0, 15)),
             ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
             {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
             ($urandom_range(0, 3) == 0));
      // small operands sometimes, so ZF and sign cases show up often
      if ($urandom_range(0, 2) == 0) begin
        valA = W'($urandom_range(0, 3)); valB = W'($urandom_range(0, 3));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== (!e_ov || out_ready)) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, in_ready, (!e_ov || out_ready));
      end
      tick();
      checks++;
      if (dut_b() !== exp_b()) begin
        errors++; $display("FAIL rand_out[%0d]: got %h want %h", n, dut_b(), exp_b());
      end
    end
    in_valid = 0; out_ready = 1; squash_cc = 0;
    $display("test_random: 400 cycles, new errors=%0d", errors - bad_before);
  endtask

  task automatic test_reset_mid();
    set_in(6, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 4'h2, 0, 0);
    tick();
    #2;
    reset = 1;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || cc_out !== 3'b001 || dstE_out !== 4'hF) begin
      errors++; $display("FAIL reset_mid: ov=%b cc=%b dstE=%h want 0 001 f", out_valid, cc_out, dstE_out);
    end
    in_valid = 0;
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    checks++;
    if (dut_b() !== exp_b()) begin
      errors++; $display("FAIL reset_mid_after: got %h want %h", dut_b(), exp_b());
    end
    $display("test_reset_mid: ov=%b cc=%b", out_valid, cc_out);
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_cmov_not_taken();
    test_stack();
    test_squash();
    test_invalid_ifun();
    test_stall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
